// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Define ALU_ARB_FWD_EN to accept the next request in the same cycle a response is taken.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CTL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [CTL_W-1:0] req0_ctl,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_data,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [CTL_W-1:0] req1_ctl,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_data,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [CTL_W-1:0] alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [CTL_W-1:0] ctl_q, ctl_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic any_valid;
  logic both_valid;
  logic rsp_ready_win;
  logic arb_last;
  logic grant_w;
  logic grant_en;
  logic accept;

  assign any_valid     = req0_valid | req1_valid;
  assign both_valid    = req0_valid & req1_valid;
  assign rsp_ready_win = win_q ? rsp1_ready : rsp0_ready;
  // In RESP the response being retired counts as the most recent grant.
  assign arb_last      = (state_q == StResp) ? win_q : last_q;
  assign grant_w       = both_valid ? ~arb_last : req1_valid;

`ifdef ALU_ARB_FWD_EN
  assign grant_en = (state_q == StIdle) | ((state_q == StResp) & rsp_ready_win);
`else
  assign grant_en = (state_q == StIdle);
`endif

  // Gated by rst_n so no handshake is signalled while reset is held.
  assign accept     = rst_n & grant_en & any_valid;
  assign req0_ready = accept & ~grant_w;
  assign req1_ready = accept & grant_w;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    ctl_d   = ctl_q;
    res_d   = res_q;
    case (state_q)
      StIdle: state_d = StIdle;
      StExec: begin
        res_d   = alu_out;
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_win) begin
          last_d  = win_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      state_d = StExec;
      win_d   = grant_w;
      op1_d   = grant_w ? req1_op1 : req0_op1;
      op2_d   = grant_w ? req1_op2 : req0_op2;
      ctl_d   = grant_w ? req1_ctl : req0_ctl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
    end
  end

  assign rsp0_valid = (state_q == StResp) & ~win_q;
  assign rsp1_valid = (state_q == StResp) & win_q;
  assign rsp0_data  = res_q;
  assign rsp1_data  = res_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_ctl    = ctl_q;
  assign busy       = (state_q != StIdle);

endmodule
